// File: rtl/bp_pht_scheduler.sv
// bp_pht_scheduler: shares a 2-bit-counter PHT between a priority lookup port and a FIFO-buffered update port, with init sequencing.
// Ports: clk, rst (async, active-high); flush; lookup_valid/lookup_idx/lookup_ready -> pred_valid/pred_taken (registered);
//        upd_valid/upd_idx/upd_taken/upd_ready; queue_count (queued updates); busy (table initialising).
module bp_pht_scheduler #(
  parameter int IDX_W  = 4,
  parameter int QDEPTH = 4,
  parameter int QPTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_idx,
  output logic              lookup_ready,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic [QPTR_W:0]   queue_count,
  output logic              busy
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] init_ptr;
  logic [1:0] pht [2**IDX_W];
  logic [IDX_W:0] q_mem [QDEPTH];
  logic [QPTR_W-1:0] head, tail;
  logic run, last, acc, enq, drn, d_tk;
  logic [IDX_W-1:0] d_idx;
  logic [1:0] d_old, d_new;
  assign run          = state == RUN;
  assign busy         = !run;
  assign last         = init_ptr == IDX_W'(2**IDX_W - 1);
  assign lookup_ready = run && !flush && queue_count != (QPTR_W+1)'(QDEPTH);
  assign upd_ready    = run && !flush && queue_count < (QPTR_W+1)'(QDEPTH);
  assign acc          = lookup_valid && lookup_ready;
  assign enq          = upd_valid && upd_ready;
  // lookups win the table port; a drain only uses cycles with no accepted lookup
  assign drn          = run && !flush && queue_count != '0 && !acc;
  assign {d_idx, d_tk} = q_mem[head];
  assign d_old        = pht[d_idx];
  assign d_new        = d_tk ? (d_old == 2'd3 ? d_old : d_old + 2'd1) : (d_old == 2'd0 ? d_old : d_old - 2'd1);
  always_comb begin
    state_nx = state;
    state_nx = flush ? INIT : (!run && last) ? RUN : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      init_ptr    <= '0;
      head        <= '0;
      tail        <= '0;
      queue_count <= '0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
    end else begin
      state       <= state_nx;
      init_ptr    <= (flush || run) ? '0 : init_ptr + 1'b1;
      head        <= flush ? '0 : head + QPTR_W'(drn);
      tail        <= flush ? '0 : tail + QPTR_W'(enq);
      queue_count <= flush ? '0 : queue_count + (QPTR_W+1)'(enq) - (QPTR_W+1)'(drn);
      pred_valid  <= acc;
      pred_taken  <= acc ? pht[lookup_idx][1] : pred_taken;
    end
  end
  // storage needs no reset: the table is rewritten by INIT and FIFO slots are only read once counted
  always_ff @(posedge clk) begin
    if (!run) pht[init_ptr] <= 2'b01;
    else if (drn) pht[d_idx] <= d_new;
    if (enq) q_mem[tail] <= {upd_idx, upd_taken};
  end
endmodule

// File: tb/tb_bp_pht_scheduler.sv
// tb_bp_pht_scheduler: self-checking bench with a queue/array reference model and directed vectors.
module tb_bp_pht_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, lookup_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic [3:0] lookup_idx = '0, upd_idx = '0;
  logic lookup_ready, pred_valid, pred_taken, upd_ready, busy;
  logic [2:0] queue_count;
  int checks = 0, errors = 0;

  bp_pht_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .queue_count(queue_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; bit tk;} upd_t;
  int tbl [16];
  upd_t mq[$];
  bit m_busy = 1'b1, m_pv = 1'b0, m_pt = 1'b0;
  int m_init = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b1; m_init = 0; mq.delete(); m_pv = 1'b0; m_pt = 1'b0;
    end else if (m_busy) begin
      m_pv = 1'b0;
      tbl[m_init] = 1;
      if (flush) m_init = 0;
      else if (m_init == 15) begin m_busy = 1'b0; m_init = 0; end
      else m_init++;
    end else if (flush) begin
      m_busy = 1'b1; m_init = 0; mq.delete(); m_pv = 1'b0;
    end else begin
      bit acc, enq;
      acc = lookup_valid && mq.size() < 4;
      enq = upd_valid && mq.size() < 4;
      m_pv = acc;
      if (acc) m_pt = tbl[lookup_idx] >= 2;
      else if (mq.size() > 0) begin
        upd_t e;
        e = mq.pop_front();
        tbl[e.idx] = e.tk ? (tbl[e.idx] < 3 ? tbl[e.idx] + 1 : 3) : (tbl[e.idx] > 0 ? tbl[e.idx] - 1 : 0);
      end
      if (enq) mq.push_back('{int'(upd_idx), upd_taken});
    end
  end

  always @(negedge clk) begin
    #2;
    chk("busy", busy, m_busy);
    chk("lookup_ready", lookup_ready, !m_busy && !flush && mq.size() < 4);
    chk("upd_ready", upd_ready, !m_busy && !flush && mq.size() < 4);
    chk("queue_count", queue_count, mq.size());
    chk("pred_valid", pred_valid, m_pv);
    chk("pred_taken", pred_taken, m_pt);
  end

  task automatic tick(input bit lv, input int li, input bit uv, input int ui, input bit ut, input bit fl);
    @(negedge clk);
    lookup_valid = lv; lookup_idx = 4'(li);
    upd_valid = uv; upd_idx = 4'(ui); upd_taken = ut; flush = fl;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic offer(input bit lv, input int ui, input bit ut);
    int n = 0;
    tick(lv, 0, 1, ui, ut, 0);
    #1;
    while (!upd_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("offer_timeout", n, 0);
  endtask

  task automatic wait_empty();
    int n = 0;
    idle(); #1;
    while (queue_count != 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("drain_timeout", n, 0);
  endtask

  task automatic predict(input int li, input bit exp, input string name);
    tick(1, li, 0, 0, 0, 0);
    idle(); #2;
    chk({name, "_valid"}, pred_valid, 1);
    chk(name, pred_taken, exp);
  endtask

  task automatic init_check(input string name);
    repeat (15) @(posedge clk);
    #1 chk({name, "_busy15"}, busy, 1);
    chk({name, "_lready15"}, lookup_ready, 0);
    @(posedge clk);
    #1 chk({name, "_busy16"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_check("init");
    predict(5, 0, "first_pred");
    offer(0, 5, 1);
    offer(0, 5, 1);
    wait_empty();
    predict(5, 1, "ctr3_pred");
    offer(0, 5, 1);
    offer(0, 5, 0);
    offer(0, 5, 0);
    offer(0, 5, 0);
    wait_empty();
    predict(5, 0, "ctr0_pred");
    for (int i = 8; i < 12; i++) offer(1, i, 1);
    @(negedge clk);
    lookup_valid = 1'b1; upd_valid = 1'b1; upd_idx = 4'd12; upd_taken = 1'b1;
    #2 chk("full_count", queue_count, 4);
    chk("full_lready", lookup_ready, 0);
    chk("full_uready", upd_ready, 0);
    @(negedge clk); #2 chk("full_drained", queue_count, 3);
    wait_empty();
    predict(8, 1, "keep8");
    predict(12, 1, "keep12");
    offer(1, 3, 1);
    offer(1, 3, 0);
    tick(0, 0, 1, 4, 1, 0);
    idle(); #2 chk("enq_drn_count", queue_count, 2);
    wait_empty();
    predict(3, 0, "order3");
    predict(4, 1, "pred4");
    for (int i = 1; i < 4; i++) offer(1, i, 1);
    tick(1, 7, 0, 0, 0, 1);
    #2 chk("flush_lready", lookup_ready, 0);
    idle(); #2;
    chk("flush_pv", pred_valid, 0);
    chk("flush_count", queue_count, 0);
    chk("flush_busy", busy, 1);
    init_check("reinit");
    predict(5, 0, "post_flush5");
    predict(8, 0, "post_flush8");
    tick(0, 0, 0, 0, 0, 1);
    idle();
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_init_busy", busy, 1);
    chk("rst_init_count", queue_count, 0);
    @(negedge clk) rst = 1'b0;
    init_check("rst_init");
    offer(1, 6, 1);
    offer(1, 6, 1);
    tick(1, 0, 0, 0, 0, 0);
    idle();
    @(posedge clk);
    #1 chk("drain_cnt_before", queue_count, 1);
    rst = 1'b1;
    #1 chk("rst_drn_count", queue_count, 0);
    chk("rst_drn_pv", pred_valid, 0);
    chk("rst_drn_pt", pred_taken, 0);
    chk("rst_drn_busy", busy, 1);
    @(negedge clk) rst = 1'b0;
    init_check("rst_drn");
    predict(6, 0, "post_rst6");
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
